counter_down_timer: RTL and testbench



---
 rtl/counter_down_timer.sv | 99 +++++++++
 tb/tb_counter_down_timer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/counter_down_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// A load captures a start value; each enabled cycle in RUN decrements the
// count, and reaching zero raises a one-cycle terminal-count pulse. In
// auto-reload mode the terminal step reloads the last loaded value instead.
module counter_down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_nextCount;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_nextReload;
    logic             r_tc;
    logic             w_nextTc;

    // State, count, reload value and terminal pulse all register together; Clr clears everything at once
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_state  <= IDLE;
            r_count  <= ZERO;
            r_reload <= ZERO;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_count  <= w_nextCount;
            r_reload <= w_nextReload;
            r_tc     <= w_nextTc;
        end
    end

    // Next-state logic: a load overrides everything, otherwise RUN counts down and intercepts the step from 1
    always_comb begin
        w_nextState  = r_state;
        w_nextCount  = r_count;
        w_nextReload = r_reload;
        w_nextTc     = 1'b0;

        if (Load) begin
            w_nextCount  = Data;
            w_nextReload = Data;
            w_nextState  = (Data != ZERO) ? RUN : IDLE;
        end else begin
            case (r_state)
                RUN: begin
                    if (Enable) begin
                        if (r_count == ONE) begin
                            w_nextTc = 1'b1;
                            if (AutoReload) begin
                                w_nextCount = r_reload;
                            end else begin
                                w_nextCount = ZERO;
                                w_nextState = DONE;
                            end
                        end else begin
                            w_nextCount = r_count - ONE;
                        end
                    end
                end
                IDLE: begin
                    w_nextState = IDLE;
                end
                DONE: begin
                    w_nextState = DONE;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    assign Q    = r_count;
    assign Busy = (r_state == RUN);
    assign Done = (r_state == DONE);
    assign Tc   = r_tc;

endmodule

// File: tb/tb_counter_down_timer.sv
// Self-checking bench for counter_down_timer: a table of input/expected
// records is applied cycle by cycle, expected outputs go through a
// scoreboard queue, and a hand-written sequence covers asynchronous Clr.
module tb_counter_down_timer;

    localparam int WIDTH = 8;

    typedef struct {
        logic             load;
        logic [WIDTH-1:0] data;
        logic             en;
        logic             ar;
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        logic             tc;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             busy;
        logic             done;
        logic             tc;
    } exp_t;

    logic             Clk;
    logic             Clr;
    logic             Enable;
    logic             Load;
    logic [WIDTH-1:0] Data;
    logic             AutoReload;
    logic [WIDTH-1:0] Q;
    logic             Busy;
    logic             Done;
    logic             Tc;

    vec_t vecs[$];
    exp_t scoreboard[$];
    int   errCount   = 0;
    int   checkCount = 0;

    counter_down_timer #(.WIDTH(WIDTH)) dut (
        .Clk        (Clk),
        .Clr        (Clr),
        .Enable     (Enable),
        .Load       (Load),
        .Data       (Data),
        .AutoReload (AutoReload),
        .Q          (Q),
        .Busy       (Busy),
        .Done       (Done),
        .Tc         (Tc)
    );

    // Free-running clock, 10 time-unit period
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic addVec(input logic ld, input logic [WIDTH-1:0] d, input logic en,
                          input logic ar, input logic [WIDTH-1:0] q, input logic b,
                          input logic dn, input logic t);
        vec_t v;
        v.load = ld; v.data = d; v.en = en; v.ar = ar;
        v.q = q; v.busy = b; v.done = dn; v.tc = t;
        vecs.push_back(v);
    endtask

    task automatic pushExpected(input logic [WIDTH-1:0] q, input logic b,
                                input logic dn, input logic t);
        exp_t e;
        e.q = q; e.busy = b; e.done = dn; e.tc = t;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        checkCount++;
        if (scoreboard.size() == 0) begin
            errCount++;
            $display("[TB] FAIL %s: scoreboard empty, got Q=%0d Busy=%0b Done=%0b Tc=%0b",
                     name, Q, Busy, Done, Tc);
        end else begin
            e = scoreboard.pop_front();
            if (Q !== e.q || Busy !== e.busy || Done !== e.done || Tc !== e.tc) begin
                errCount++;
                $display("[TB] FAIL %s: got Q=%0d Busy=%0b Done=%0b Tc=%0b, expected Q=%0d Busy=%0b Done=%0b Tc=%0b",
                         name, Q, Busy, Done, Tc, e.q, e.busy, e.done, e.tc);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        Load       = v.load;
        Data       = v.data;
        Enable     = v.en;
        AutoReload = v.ar;
        pushExpected(v.q, v.busy, v.done, v.tc);
        @(posedge Clk);
        #1;
        checkOutput(name);
    endtask

    // Main test sequence: reset check, table of vectors, then asynchronous Clr mid-run
    initial begin
        vec_t v;

        Clr = 1'b1; Load = 1'b0; Data = '0; Enable = 1'b0; AutoReload = 1'b0;
        #3;
        pushExpected(8'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state");
        @(posedge Clk);
        #1;
        Clr = 1'b0;

        // One-shot load of 5: 5,4,3,2,1,0 with Tc in the Q=0 cycle, then DONE holds
        addVec(1, 8'd5, 1, 0, 8'd5, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd4, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd3, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd2, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd1, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd0, 0, 1, 1);
        for (int k = 0; k < 10; k++) addVec(0, 8'd0, 1, 0, 8'd0, 0, 1, 0);

        // Auto-reload of 3 from DONE: 3,2,1,3,... with Tc coincident with the reload
        addVec(1, 8'd3, 1, 1, 8'd3, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            if (k % 3 == 0) addVec(0, 8'd0, 1, 1, 8'd3, 1, 0, 1);
            else            addVec(0, 8'd0, 1, 1, 8'(3 - (k % 3)), 1, 0, 0);
        end

        // Enable gating: load 4 with Enable high (no decrement), then pattern 1,0,0,1,1,0,1
        addVec(1, 8'd4, 1, 0, 8'd4, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd3, 1, 0, 0);
        addVec(0, 8'd0, 0, 0, 8'd3, 1, 0, 0);
        addVec(0, 8'd0, 0, 0, 8'd3, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd2, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd1, 1, 0, 0);
        addVec(0, 8'd0, 0, 0, 8'd1, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd0, 0, 1, 1);

        // Priority: load 9 on the terminal step suppresses Tc; load 0 goes to IDLE
        addVec(1, 8'd2, 1, 0, 8'd2, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd1, 1, 0, 0);
        addVec(1, 8'd9, 1, 0, 8'd9, 1, 0, 0);
        addVec(0, 8'd0, 0, 0, 8'd9, 1, 0, 0);
        addVec(1, 8'd0, 1, 0, 8'd0, 0, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd0, 0, 0, 0);
        addVec(0, 8'd0, 1, 1, 8'd0, 0, 0, 0);

        // AutoReload dropped mid-count takes effect at the terminal step
        addVec(1, 8'd2, 1, 1, 8'd2, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd1, 1, 0, 0);
        addVec(0, 8'd0, 1, 0, 8'd0, 0, 1, 1);

        // Boundary: all-ones load reaches terminal after exactly 255 enabled cycles
        addVec(1, 8'hFF, 1, 0, 8'hFF, 1, 0, 0);
        for (int k = 1; k <= 255; k++) begin
            if (k == 255) addVec(0, 8'd0, 1, 0, 8'd0, 0, 1, 1);
            else          addVec(0, 8'd0, 1, 0, 8'(255 - k), 1, 0, 0);
        end
        addVec(0, 8'd0, 1, 0, 8'd0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous Clr mid-RUN with Q=0x37 clears outputs before the next edge
        v.load = 1; v.data = 8'h37; v.en = 0; v.ar = 0;
        v.q = 8'h37; v.busy = 1; v.done = 0; v.tc = 0;
        applyStimulus(v, "clr_setup_load");
        v.load = 0; v.data = 8'h00;
        applyStimulus(v, "clr_setup_hold");
        #2;
        Clr = 1'b1;
        #1;
        pushExpected(8'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("clr_async");
        @(posedge Clk);
        #2;
        Clr = 1'b0;
        v.load = 0; v.data = 8'h00; v.en = 1; v.ar = 1;
        v.q = 8'd0; v.busy = 0; v.done = 0; v.tc = 0;
        for (int k = 0; k < 3; k++) applyStimulus(v, $sformatf("clr_idle%0d", k));

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
